// File: rtl/scan_capture_seq.sv
// Mux scan sequencer: steps S through channels 0..3 with a programmable dwell,
// samples Ym at the end of each dwell and hands the 4-bit word out over valid/ready.
module scan_capture_seq #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cont,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               Ym,
  output logic [1:0]         S,
  output logic               busy,
  output logic [3:0]         word,
  output logic               word_valid,
  input  logic               word_ready,
  output logic               overrun,
  input  logic               clr_ovr
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t             r_state, w_next;
  logic [DWELL_W-1:0] r_cnt, r_dl;
  logic [1:0]         r_s;
  logic [2:0]         r_shadow;
  logic [3:0]         r_word;
  logic               r_valid, r_ovr;
  logic [DWELL_W-1:0] w_dl_in;
  logic               w_done;

  // A dwell of zero still holds each channel for one cycle.
  assign w_dl_in = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign w_done  = (r_state == SCAN) && !abort && (r_cnt == '0) && (r_s == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start && !abort) w_next = SCAN;
      SCAN: begin
        if (abort)               w_next = IDLE;
        else if (w_done && !cont) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_dl     <= DWELL_W'(1);
      r_s      <= 2'd0;
      r_shadow <= 3'd0;
      r_word   <= 4'd0;
      r_valid  <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (r_valid && word_ready) r_valid <= 1'b0;
      if (clr_ovr)               r_ovr   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_s <= 2'd0;
          if (start && !abort) begin
            r_dl     <= w_dl_in;
            r_cnt    <= w_dl_in - DWELL_W'(1);
            r_shadow <= 3'd0;
          end
        end
        SCAN: begin
          if (abort) begin
            r_s      <= 2'd0;
            r_cnt    <= '0;
            r_shadow <= 3'd0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - DWELL_W'(1);
          end else if (r_s != 2'd3) begin
            case (r_s)
              2'd0:    r_shadow[0] <= Ym;
              2'd1:    r_shadow[1] <= Ym;
              default: r_shadow[2] <= Ym;
            endcase
            r_s   <= r_s + 2'd1;
            r_cnt <= r_dl - DWELL_W'(1);
          end else begin
            r_word   <= {Ym, r_shadow};
            r_valid  <= 1'b1;
            // Set beats a same-edge clr_ovr because it is assigned last.
            if (r_valid && !word_ready) r_ovr <= 1'b1;
            r_s      <= 2'd0;
            r_shadow <= 3'd0;
            if (cont) begin
              r_dl  <= w_dl_in;
              r_cnt <= w_dl_in - DWELL_W'(1);
            end
          end
        end
        default: r_s <= 2'd0;
      endcase
    end
  end

  assign S          = r_s;
  assign busy       = (r_state == SCAN);
  assign word       = r_word;
  assign word_valid = r_valid;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_scan_capture_seq.sv
// Directed bench for scan_capture_seq with a behavioural 4:1 mux driving Ym.
module tb_scan_capture_seq;
  logic       clk = 1'b0;
  logic       rst, start, cont, abort, Ym, word_ready, clr_ovr;
  logic [7:0] dwell;
  logic [1:0] S;
  logic       busy, word_valid, overrun;
  logic [3:0] word;
  logic [3:0] Im;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign Ym = Im[S];

  scan_capture_seq #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
    .dwell(dwell), .Ym(Ym), .S(S), .busy(busy), .word(word),
    .word_valid(word_valid), .word_ready(word_ready), .overrun(overrun),
    .clr_ovr(clr_ovr)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic kick();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; cont = 0; abort = 0; dwell = 8'd1;
    word_ready = 1'b1; clr_ovr = 0; Im = 4'h0;
    tick(); tick();
    checks++;
    if ({S, busy, word, word_valid, overrun} !== 9'd0) begin
      errors++; $display("FAIL reset_outputs got %b exp %b", {S, busy, word, word_valid, overrun}, 9'd0);
    end
    rst = 1'b0; tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b exp 0", busy); end
  endtask

  task automatic test_single_scan();
    Im = 4'b1010; dwell = 8'd3; word_ready = 1'b1;
    kick();
    for (int j = 0; j < 12; j++) begin
      checks++;
      if (S !== 2'(j / 3) || busy !== 1'b1 || word_valid !== 1'b0) begin
        errors++; $display("FAIL single_seq t0+%0d S=%0d busy=%b v=%b exp S=%0d busy=1 v=0", j, S, busy, word_valid, j / 3);
      end
      tick();
    end
    checks++;
    if (word !== 4'b1010 || word_valid !== 1'b1 || busy !== 1'b0 || S !== 2'd0) begin
      errors++; $display("FAIL single_done word=%b v=%b busy=%b S=%0d exp 1010 1 0 0", word, word_valid, busy, S);
    end
    tick();
    checks++;
    if (word_valid !== 1'b0) begin errors++; $display("FAIL single_xfer v got %b exp 0", word_valid); end
  endtask

  task automatic test_dwell_zero();
    Im = 4'b0110; dwell = 8'd0;
    kick();
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (S !== 2'(j)) begin errors++; $display("FAIL dwell0_S t0+%0d got %0d exp %0d", j, S, j); end
      tick();
    end
    checks++;
    if (word !== 4'b0110 || word_valid !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL dwell0_word word=%b v=%b busy=%b exp 0110 1 0", word, word_valid, busy);
    end
    tick();
  endtask

  task automatic test_cont_overrun();
    Im = 4'b1111; dwell = 8'd2; cont = 1'b1; word_ready = 1'b0;
    kick();
    repeat (7) tick();
    checks++;
    if (word_valid !== 1'b0) begin errors++; $display("FAIL cont_early v got %b exp 0", word_valid); end
    tick();
    checks++;
    if (word !== 4'b1111 || word_valid !== 1'b1 || overrun !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL cont_first word=%b v=%b ovr=%b busy=%b exp 1111 1 0 1", word, word_valid, overrun, busy);
    end
    Im = 4'b0001;
    repeat (7) tick();
    clr_ovr = 1'b1;
    tick();
    checks++;
    if (word !== 4'b0001 || word_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++; $display("FAIL cont_overrun word=%b v=%b ovr=%b exp 0001 1 1", word, word_valid, overrun);
    end
    cont = 1'b0;
    tick();
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL clr_ovr got %b exp 0", overrun); end
    clr_ovr = 1'b0;
    repeat (7) tick();
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b1) begin
      errors++; $display("FAIL cont_stop busy=%b ovr=%b exp 0 1", busy, overrun);
    end
    word_ready = 1'b1; clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    checks++;
    if (word_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL cont_drain v=%b ovr=%b exp 0 0", word_valid, overrun);
    end
  endtask

  task automatic test_abort();
    Im = 4'b1010; dwell = 8'd1;
    kick();
    tick(); tick();
    checks++;
    if (S !== 2'd2) begin errors++; $display("FAIL abort_pre S got %0d exp 2", S); end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || S !== 2'd0 || word_valid !== 1'b0) begin
      errors++; $display("FAIL abort busy=%b S=%0d v=%b exp 0 0 0", busy, S, word_valid);
    end
    tick();
    Im = 4'b0101;
    kick();
    repeat (4) tick();
    checks++;
    if (word !== 4'b0101 || word_valid !== 1'b1) begin
      errors++; $display("FAIL abort_rescan word=%b v=%b exp 0101 1", word, word_valid);
    end
    tick();
  endtask

  task automatic test_ignored_inputs();
    Im = 4'b1100; dwell = 8'd4;
    start = 1'b1; tick();
    dwell = 8'd5;
    repeat (14) tick();
    start = 1'b0;
    tick();
    checks++;
    if (word_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL ignored_t15 v=%b busy=%b exp 0 1", word_valid, busy);
    end
    tick();
    checks++;
    if (word_valid !== 1'b1 || word !== 4'b1100 || busy !== 1'b0) begin
      errors++; $display("FAIL ignored_t16 v=%b word=%b busy=%b exp 1 1100 0", word_valid, word, busy);
    end
    tick();
  endtask

  task automatic test_max_dwell();
    Im = 4'b1001; dwell = 8'd255;
    kick();
    repeat (1019) tick();
    checks++;
    if (word_valid !== 1'b0 || busy !== 1'b1 || S !== 2'd3) begin
      errors++; $display("FAIL maxdwell_pre v=%b busy=%b S=%0d exp 0 1 3", word_valid, busy, S);
    end
    tick();
    checks++;
    if (word_valid !== 1'b1 || word !== 4'b1001) begin
      errors++; $display("FAIL maxdwell_done v=%b word=%b exp 1 1001", word_valid, word);
    end
    tick();
  endtask

  task automatic test_async_reset();
    Im = 4'b1111; dwell = 8'd1; cont = 1'b1; word_ready = 1'b0;
    kick();
    repeat (7) tick();
    checks++;
    if (word_valid !== 1'b1 || S !== 2'd3) begin
      errors++; $display("FAIL areset_pre v=%b S=%0d exp 1 3", word_valid, S);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (word !== 4'd0 || word_valid !== 1'b0 || S !== 2'd0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL areset word=%b v=%b S=%0d busy=%b ovr=%b exp all 0", word, word_valid, S, busy, overrun);
    end
    cont = 1'b0; word_ready = 1'b1;
    #1 rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_scan();
    test_dwell_zero();
    test_cont_overrun();
    test_abort();
    test_ignored_inputs();
    test_max_dwell();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
